// File: rtl/fir_out_decim_if.sv
// Output stream of fir_out_decim: averaged 5.3 sample with saturation flag,
// valid/ready handshake. The master drives data/valid, the slave drives ready.
interface fir_out_decim_if;
  logic [7:0] Dout;
  logic       Dout_sat;
  logic       Dout_valid;
  logic       Dout_ready;

  modport master (
    output Dout,
    output Dout_sat,
    output Dout_valid,
    input  Dout_ready
  );

  modport slave (
    input  Dout,
    input  Dout_sat,
    input  Dout_valid,
    output Dout_ready
  );
endinterface

// File: rtl/fir_out_decim.sv
// FIR output post-processing: discards pipeline warm-up samples, averages
// groups of DECIM samples, rounds/saturates 8.8 -> 5.3 and queues the results
// in a show-ahead FIFO behind a valid/ready handshake.
module fir_out_decim #(
  parameter int DECIM       = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int FILL_CYCLES = 7
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic [15:0]     Yin,
  fir_out_decim_if.master dout_if,
  output logic            Ovf
);

  localparam int LG = $clog2(DECIM);
  localparam int AW = 16 + LG;
  localparam int K  = LG + 5;
  localparam int RW = AW + 1 - K;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int FW = (FILL_CYCLES > 2) ? $clog2(FILL_CYCLES) : 1;

  localparam logic [AW:0]   RND      = {{(AW + 1 - K){1'b0}}, 1'b1, {(K - 1){1'b0}}};
  localparam logic [FW-1:0] FILL_END = FW'(FILL_CYCLES - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic {
    WARM,
    RUN
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [FW-1:0]   r_fill;
  logic [LG-1:0]   r_g;
  logic [AW-1:0]   r_acc;
  logic            r_pend;
  logic [8:0]      r_res;
  logic [8:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wp;
  logic [PW-1:0]   r_rp;
  logic [CW-1:0]   r_cnt;
  logic            r_ovf;

  logic [AW-1:0]   w_yin_ext;
  logic [AW-1:0]   w_sum;
  logic [AW:0]     w_rnd;
  logic [RW-1:0]   w_r;
  logic            w_sat;
  logic [7:0]      w_dat;
  logic            w_last;
  logic            w_valid;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic [8:0]      w_head;
  logic            w_unused_rnd;

  // Next-state logic: leave WARM once the pipeline fill has been discarded.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WARM:    if (r_fill == FILL_END) w_state_nxt = RUN;
      RUN:     w_state_nxt = RUN;
      default: w_state_nxt = WARM;
    endcase
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) r_state <= WARM;
    else     r_state <= w_state_nxt;
  end

  // Warm-up fill counter, counts discarded samples while in WARM.
  always_ff @(posedge Clk) begin
    if (Rst)
      r_fill <= '0;
    else if (r_state == WARM && r_fill != FILL_END)
      r_fill <= r_fill + FW'(1);
  end

  assign w_yin_ext = {{LG{1'b0}}, Yin};
  assign w_sum     = r_acc + w_yin_ext;
  assign w_last    = (r_state == RUN) && (r_g == '1);

  // Group counter and accumulator; the first sample of a group reloads.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_g   <= '0;
      r_acc <= '0;
    end else if (r_state == RUN) begin
      r_g   <= r_g + LG'(1);
      r_acc <= (r_g == '0) ? w_yin_ext : w_sum;
    end
  end

  // Divide by DECIM and drop 5 fraction bits in one shift, round half up.
  assign w_rnd        = {1'b0, w_sum} + RND;
  assign w_r          = w_rnd[AW:K];
  assign w_sat        = |w_r[RW-1:8];
  assign w_dat        = w_sat ? 8'hFF : w_r[7:0];
  assign w_unused_rnd = ^w_rnd[K-1:0];

  // Result register; pending lasts exactly one cycle (pushed or dropped).
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_pend <= 1'b0;
      r_res  <= '0;
    end else begin
      r_pend <= w_last;
      if (w_last) r_res <= {w_sat, w_dat};
    end
  end

  assign w_valid = (r_cnt != '0);
  assign w_full  = (r_cnt == FULL_CNT);
  assign w_pop   = w_valid && dout_if.Dout_ready;
  assign w_push  = r_pend && (!w_full || w_pop);
  assign w_drop  = r_pend && w_full && !w_pop;

  // FIFO storage; contents are irrelevant while the count is zero.
  always_ff @(posedge Clk) begin
    if (w_push) r_mem[r_wp] <= r_res;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_pop)  r_rp <= r_rp + PW'(1);
      if (w_push && !w_pop)      r_cnt <= r_cnt + CW'(1);
      else if (w_pop && !w_push) r_cnt <= r_cnt - CW'(1);
    end
  end

  // Sticky overflow flag.
  always_ff @(posedge Clk) begin
    if (Rst)         r_ovf <= 1'b0;
    else if (w_drop) r_ovf <= 1'b1;
  end

  assign w_head             = r_mem[r_rp];
  assign dout_if.Dout_valid = w_valid;
  assign dout_if.Dout       = w_valid ? w_head[7:0] : '0;
  assign dout_if.Dout_sat   = w_valid ? w_head[8] : 1'b0;
  assign Ovf                = r_ovf;

endmodule

// File: tb/tb_fir_out_decim.sv
// Bench for fir_out_decim: directed scenarios plus a randomized run, checked
// every cycle against a sample-list/queue reference model.
module tb_fir_out_decim;

  localparam int DECIM = 4;
  localparam int DEPTH = 4;
  localparam int FILL  = 7;
  localparam int K     = 7;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [15:0] Yin = '0;
  logic        Ovf;

  fir_out_decim_if u_if ();

  fir_out_decim #(
    .DECIM      (DECIM),
    .FIFO_DEPTH (DEPTH),
    .FILL_CYCLES(FILL)
  ) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .Yin    (Yin),
    .dout_if(u_if),
    .Ovf    (Ovf)
  );

  always #5 Clk = ~Clk;

  // Reference model state
  int          m_cyc;
  int unsigned m_grp[$];
  bit          m_pend;
  logic [8:0]  m_pval;
  logic [8:0]  m_q[$];
  bit          m_ovf;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 1;
  int          first_cyc = 0;
  bit          seen = 0;
  logic [8:0]  first_val = '0;
  logic [8:0]  obs[$];

  function automatic logic [8:0] convert(input int unsigned s);
    int unsigned r;
    r = (s + (1 << (K - 1))) >> K;
    if (r > 255) return {1'b1, 8'hFF};
    return {1'b0, 8'(r)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0;
    m_grp.delete();
    m_pend = 0;
    m_pval = '0;
    m_q.delete();
    m_ovf = 0;
    cyc = 1;
    seen = 0;
    first_cyc = 0;
    first_val = '0;
    obs.delete();
  endtask

  // One clock cycle: apply inputs, check outputs mid-cycle, advance the model.
  task automatic step(input bit rst, input logic [15:0] y, input bit rdy);
    bit          exp_valid;
    logic [8:0]  exp_word;
    bit          pop;
    bit          was_full;
    int unsigned s;
    Rst = rst;
    Yin = y;
    u_if.Dout_ready = rdy;
    @(negedge Clk);
    exp_valid = (m_q.size() != 0);
    exp_word  = exp_valid ? m_q[0] : 9'h000;
    chk("valid", 32'(u_if.Dout_valid), 32'(exp_valid));
    chk("dout",  32'(u_if.Dout),       32'(exp_word[7:0]));
    chk("sat",   32'(u_if.Dout_sat),   32'(exp_word[8]));
    chk("ovf",   32'(Ovf),             32'(m_ovf));
    if (u_if.Dout_valid && !seen) begin
      seen      = 1;
      first_cyc = cyc;
      first_val = {u_if.Dout_sat, u_if.Dout};
    end
    if (u_if.Dout_valid && rdy) obs.push_back({u_if.Dout_sat, u_if.Dout});
    @(posedge Clk);
    if (rst) begin
      model_reset();
    end else begin
      pop      = (m_q.size() != 0) && rdy;
      was_full = (m_q.size() == DEPTH);
      if (pop) void'(m_q.pop_front());
      if (m_pend) begin
        if (!was_full || pop) m_q.push_back(m_pval);
        else                  m_ovf = 1;
      end
      m_pend = 0;
      if (m_cyc >= FILL) begin
        m_grp.push_back(int'(y));
        if (m_grp.size() == DECIM) begin
          s = 0;
          foreach (m_grp[i]) s += m_grp[i];
          m_pval = convert(s);
          m_pend = 1;
          m_grp.delete();
        end
      end
      m_cyc++;
      cyc++;
    end
    #1;
  endtask

  task automatic reset_warm(input logic [15:0] y);
    step(1, 16'($urandom), 1'($urandom));
    for (int i = 0; i < FILL; i++) step(0, y, 1);
  endtask

  logic [15:0] pat[24];
  logic [8:0]  exp_pat[6];

  initial begin
    u_if.Dout_ready = 1'b0;
    @(posedge Clk);
    #1;
    model_reset();

    // Warm-up discard and first-output latency
    step(1, 16'hFFFF, 1);
    for (int i = 0; i < FILL; i++) step(0, 16'hFFFF, 1);
    for (int i = 0; i < 10; i++)   step(0, 16'h0100, 1);
    chk("first_valid_cycle", 32'(first_cyc), 32'd13);
    chk("first_value",       32'(first_val), 32'h008);

    // Rounding and saturation boundaries
    pat = '{16'h0010, 16'h0010, 16'h0010, 16'h0010,
            16'h000F, 16'h000F, 16'h000F, 16'h000F,
            16'h0100, 16'h0200, 16'h0300, 16'h0400,
            16'h2000, 16'h2000, 16'h2000, 16'h2000,
            16'h1FE0, 16'h1FE0, 16'h1FE0, 16'h1FE0,
            16'h1FC0, 16'h1FC0, 16'h1FC0, 16'h1FC0};
    exp_pat = '{9'h001, 9'h000, 9'h014, 9'h1FF, 9'h0FF, 9'h0FE};
    reset_warm(16'($urandom));
    for (int i = 0; i < 24; i++) step(0, pat[i], 1);
    for (int i = 0; i < 3; i++)  step(0, 16'h0000, 1);
    chk("round_count", 32'(obs.size() >= 6), 32'd1);
    for (int i = 0; i < 6; i++) chk("round_value", 32'(obs[i]), 32'(exp_pat[i]));

    // Backpressure and overflow
    reset_warm(16'hFFFF);
    for (int n = 1; n <= 5; n++)
      for (int j = 0; j < DECIM; j++) step(0, 16'(n * 256), 0);
    step(0, 16'h0000, 0);
    step(0, 16'h0000, 0);
    chk("ovf_set", 32'(Ovf), 32'd1);
    for (int i = 0; i < 6; i++) step(0, 16'h0000, 1);
    chk("drain_count", 32'(obs.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++) chk("drain_value", 32'(obs[i]), 32'(8 * (i + 1)));
    chk("ovf_sticky", 32'(Ovf), 32'd1);

    // Full FIFO with a pop in the push cycle
    reset_warm(16'h0000);
    for (int n = 1; n <= 5; n++)
      for (int j = 0; j < DECIM; j++)
        step(0, 16'(n * 256), m_pend && (m_q.size() == DEPTH));
    step(0, 16'h0000, m_pend && (m_q.size() == DEPTH));
    step(0, 16'h0000, 0);
    step(0, 16'h0000, 0);
    chk("ovf_clear_simul", 32'(Ovf), 32'd0);
    for (int i = 0; i < 5; i++) step(0, 16'h0000, 1);
    chk("simul_count", 32'(obs.size() >= 5), 32'd1);
    for (int i = 0; i < 5; i++) chk("simul_value", 32'(obs[i]), 32'(8 * (i + 1)));

    // Reset mid-group with entries queued
    reset_warm(16'h0000);
    for (int i = 0; i < 2 * DECIM + 2; i++) step(0, 16'hFFFF, 0);
    step(1, 16'hFFFF, 0);
    chk("rst_valid", 32'(u_if.Dout_valid), 32'd0);
    chk("rst_ovf",   32'(Ovf),             32'd0);
    for (int i = 0; i < FILL; i++) step(0, 16'hFFFF, 1);
    for (int i = 0; i < 10; i++)   step(0, 16'h0300, 1);
    chk("rst_first_cycle", 32'(first_cyc), 32'd13);
    chk("rst_first_value", 32'(first_val), 32'h018);

    // Randomized traffic with varying backpressure and occasional resets
    reset_warm(16'($urandom));
    for (int i = 0; i < 600; i++) begin
      logic [15:0] y;
      bit          rdy;
      y   = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h2100));
      rdy = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step(($urandom_range(0, 149) == 0), y, rdy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
